// File: rtl/snoop_txn_controller.sv
// Per-transaction MOESI snoop sequencer: broadcasts one granted request, gathers
// per-core acks, selects owner-cache or memory as data source, and reports one completion.
module snoop_txn_controller #(
    parameter int NUM_CORES      = 4,
    parameter int ADDR_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [1:0]            i_req_core,
    input  logic [1:0]            i_req_type,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    output logic                  o_snp_valid,
    output logic [1:0]            o_snp_type,
    output logic [ADDR_WIDTH-1:0] o_snp_addr,
    output logic [1:0]            o_snp_src,
    input  logic [NUM_CORES-1:0]  i_snp_ack,
    input  logic [NUM_CORES-1:0]  i_snp_shared,
    input  logic [NUM_CORES-1:0]  i_snp_owner,
    input  logic                  i_c2c_done,
    output logic                  o_mem_req_valid,
    input  logic                  i_mem_req_ready,
    output logic                  o_mem_req_write,
    output logic [ADDR_WIDTH-1:0] o_mem_req_addr,
    input  logic                  i_mem_resp_valid,
    output logic                  o_done_valid,
    output logic [1:0]            o_done_core,
    output logic                  o_done_shared,
    output logic                  o_done_from_cache,
    output logic                  o_done_error,
    output logic                  o_busy
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] T_RD   = 2'b00;
    localparam logic [1:0] T_UPGR = 2'b10;
    localparam logic [1:0] T_WB   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_SNOOP, S_COLLECT, S_MEM_REQ, S_MEM_WAIT, S_C2C_WAIT, S_DONE
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [1:0]              r_core, r_type;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [NUM_CORES-1:0]    r_ack, r_shared, r_owner;
    logic [TW-1:0]           r_tmo;
    logic                    r_err, r_fc;

    logic [NUM_CORES-1:0]    w_src_bit, w_ack_eff;
    logic [NUM_CORES-1:0]    w_ack_new, w_shared_new, w_owner_new;
    logic                    w_complete, w_multi_owner, w_expire, w_waiting;
    logic                    w_err_nxt, w_fc_nxt, w_tmo_clr;

    // Requester's own ack/flags never count toward completion or data source.
    assign w_src_bit     = {{(NUM_CORES-1){1'b0}}, 1'b1} << r_core;
    assign w_ack_eff     = i_snp_ack & ~w_src_bit;
    assign w_ack_new     = r_ack | w_ack_eff;
    assign w_shared_new  = r_shared | (w_ack_eff & i_snp_shared);
    assign w_owner_new   = r_owner | (w_ack_eff & i_snp_owner);
    assign w_complete    = ((w_ack_new | w_src_bit) == {NUM_CORES{1'b1}});
    assign w_multi_owner = ((w_owner_new & (w_owner_new - 1'b1)) != '0);
    // Expiry fires in the cycle whose increment would reach the limit.
    assign w_expire      = (r_tmo >= TW'(TIMEOUT_CYCLES - 1));
    assign w_waiting     = (r_state == S_COLLECT) || (r_state == S_MEM_REQ) ||
                           (r_state == S_MEM_WAIT) || (r_state == S_C2C_WAIT);

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = 1'b0;
        w_fc_nxt    = 1'b0;
        w_tmo_clr   = 1'b0;
        case (r_state)
            S_IDLE:  if (i_req_valid) w_state_nxt = S_SNOOP;
            S_SNOOP: begin
                w_state_nxt = S_COLLECT;
                w_tmo_clr   = 1'b1;
            end
            S_COLLECT: begin
                if (w_complete) begin
                    if (w_multi_owner) begin
                        w_state_nxt = S_DONE;
                        w_err_nxt   = 1'b1;
                    end else if (r_type == T_UPGR) begin
                        w_state_nxt = S_DONE;
                    end else if (r_type != T_WB && w_owner_new != '0) begin
                        w_state_nxt = S_C2C_WAIT;
                        w_tmo_clr   = 1'b1;
                    end else begin
                        w_state_nxt = S_MEM_REQ;
                        w_tmo_clr   = 1'b1;
                    end
                end else if (w_expire) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = 1'b1;
                end
            end
            S_MEM_REQ: begin
                if (i_mem_req_ready) begin
                    w_state_nxt = S_MEM_WAIT;
                end else if (w_expire) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                if (i_mem_resp_valid) begin
                    w_state_nxt = S_DONE;
                end else if (w_expire) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = 1'b1;
                end
            end
            S_C2C_WAIT: begin
                if (i_c2c_done) begin
                    w_state_nxt = S_DONE;
                    w_fc_nxt    = 1'b1;
                end else if (w_expire) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_core   <= '0;
            r_type   <= '0;
            r_addr   <= '0;
            r_ack    <= '0;
            r_shared <= '0;
            r_owner  <= '0;
            r_tmo    <= '0;
            r_err    <= 1'b0;
            r_fc     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && i_req_valid) begin
                r_core   <= i_req_core;
                r_type   <= i_req_type;
                r_addr   <= i_req_addr;
                r_ack    <= '0;
                r_shared <= '0;
                r_owner  <= '0;
            end
            if (r_state == S_COLLECT) begin
                r_ack    <= w_ack_new;
                r_shared <= w_shared_new;
                r_owner  <= w_owner_new;
            end
            if (w_tmo_clr) begin
                r_tmo <= '0;
            end else if (w_waiting && r_tmo != TW'(TIMEOUT_CYCLES)) begin
                r_tmo <= r_tmo + TW'(1);
            end
            if (w_state_nxt == S_DONE) begin
                r_err <= w_err_nxt;
                r_fc  <= w_fc_nxt;
            end
        end
    end

    assign o_req_ready       = (r_state == S_IDLE);
    assign o_busy            = (r_state != S_IDLE);
    assign o_snp_valid       = (r_state == S_SNOOP);
    assign o_snp_type        = r_type;
    assign o_snp_addr        = r_addr;
    assign o_snp_src         = r_core;
    assign o_mem_req_valid   = (r_state == S_MEM_REQ);
    assign o_mem_req_write   = ((r_state == S_MEM_REQ) || (r_state == S_MEM_WAIT)) && (r_type == T_WB);
    assign o_mem_req_addr    = r_addr;
    assign o_done_valid      = (r_state == S_DONE);
    assign o_done_core       = r_core;
    assign o_done_shared     = (r_state == S_DONE) && (r_type == T_RD) && ((r_shared | r_owner) != '0);
    assign o_done_from_cache = (r_state == S_DONE) && r_fc;
    assign o_done_error      = (r_state == S_DONE) && r_err;

endmodule

// File: tb/tb_snoop_txn_controller.sv
// Directed bench for snoop_txn_controller: hand-computed cycle-accurate expectations
// for each request type, timeout, multi-owner error and mid-transaction reset.
module tb_snoop_txn_controller;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [1:0]  req_core, req_type;
    logic [63:0] req_addr;
    logic        snp_valid;
    logic [1:0]  snp_type, snp_src;
    logic [63:0] snp_addr;
    logic [3:0]  snp_ack, snp_shared, snp_owner;
    logic        c2c_done;
    logic        mem_req_valid, mem_req_ready, mem_req_write;
    logic [63:0] mem_req_addr;
    logic        mem_resp_valid;
    logic        done_valid, done_shared, done_from_cache, done_error, busy;
    logic [1:0]  done_core;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    snoop_txn_controller #(.NUM_CORES(4), .ADDR_WIDTH(64), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_core(req_core), .i_req_type(req_type), .i_req_addr(req_addr),
        .o_snp_valid(snp_valid), .o_snp_type(snp_type), .o_snp_addr(snp_addr), .o_snp_src(snp_src),
        .i_snp_ack(snp_ack), .i_snp_shared(snp_shared), .i_snp_owner(snp_owner),
        .i_c2c_done(c2c_done),
        .o_mem_req_valid(mem_req_valid), .i_mem_req_ready(mem_req_ready),
        .o_mem_req_write(mem_req_write), .o_mem_req_addr(mem_req_addr),
        .i_mem_resp_valid(mem_resp_valid),
        .o_done_valid(done_valid), .o_done_core(done_core), .o_done_shared(done_shared),
        .o_done_from_cache(done_from_cache), .o_done_error(done_error), .o_busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_done(input string tag, input logic [1:0] core, input logic sh,
                            input logic fc, input logic err);
        chk({tag, "_done_valid"}, done_valid, 1'b1);
        chk({tag, "_done_core"}, done_core, core);
        chk({tag, "_done_shared"}, done_shared, sh);
        chk({tag, "_done_from_cache"}, done_from_cache, fc);
        chk({tag, "_done_error"}, done_error, err);
    endtask

    // Present a request in cycle T; returns positioned in cycle T+2 (first COLLECT cycle).
    task automatic issue(input string tag, input logic [1:0] core, input logic [1:0] typ,
                         input logic [63:0] addr);
        req_valid = 1'b1; req_core = core; req_type = typ; req_addr = addr;
        chk({tag, "_ready_T"}, req_ready, 1'b1);
        step();
        req_valid = 1'b0; req_core = 2'd0; req_type = 2'd0; req_addr = 64'd0;
        chk({tag, "_snp_valid_T1"}, snp_valid, 1'b1);
        chk({tag, "_snp_src"}, snp_src, core);
        chk({tag, "_snp_type"}, snp_type, typ);
        chk({tag, "_snp_addr"}, snp_addr, addr);
        chk({tag, "_ready_T1"}, req_ready, 1'b0);
        step();
        chk({tag, "_snp_valid_T2"}, snp_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_core = 2'd0; req_type = 2'd0; req_addr = 64'd0;
        snp_ack = 4'd0; snp_shared = 4'd0; snp_owner = 4'd0; c2c_done = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        step(); step();
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_snp_valid", snp_valid, 1'b0);
        chk("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk("rst_done_valid", done_valid, 1'b0);
        chk("rst_snp_addr", snp_addr, 64'd0);
        rst_n = 1'b1;
        step();

        // Core 2 BusUpgr, minimum latency.
        issue("upgr", 2'd2, 2'b10, 64'h1000);
        snp_ack = 4'b1011;
        step();
        snp_ack = 4'd0;
        chk_done("upgr", 2'd2, 1'b0, 1'b0, 1'b0);
        chk("upgr_ready_at_done", req_ready, 1'b0);
        step();
        chk("upgr_done_one_cycle", done_valid, 1'b0);
        chk("upgr_ready_after", req_ready, 1'b1);

        // Core 0 BusRd, core 3 owner supplies data cache-to-cache.
        issue("c2c", 2'd0, 2'b00, 64'h40);
        snp_ack = 4'b1110; snp_owner = 4'b1000;
        step();
        snp_ack = 4'd0; snp_owner = 4'd0;
        for (int i = 3; i <= 5; i++) begin
            chk("c2c_no_mem_req", mem_req_valid, 1'b0);
            chk("c2c_no_early_done", done_valid, 1'b0);
            step();
        end
        c2c_done = 1'b1;
        step();
        c2c_done = 1'b0;
        chk_done("c2c", 2'd0, 1'b1, 1'b1, 1'b0);
        step();

        // Core 1 BusRdX, staggered acks, own spurious owner ack ignored, slow memory.
        issue("rdx", 2'd1, 2'b01, 64'hABCD_0000_1234_5678);
        snp_ack = 4'b0011; snp_owner = 4'b0010;
        step();
        snp_ack = 4'd0; snp_owner = 4'd0;
        step();
        snp_ack = 4'b0100;
        step();
        snp_ack = 4'b1000;
        chk("rdx_not_complete_T5", mem_req_valid, 1'b0);
        step();
        snp_ack = 4'd0;
        for (int i = 6; i <= 8; i++) begin
            chk("rdx_mem_req_held", mem_req_valid, 1'b1);
            step();
        end
        chk("rdx_mem_write", mem_req_write, 1'b0);
        chk("rdx_mem_addr", mem_req_addr, 64'hABCD_0000_1234_5678);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk("rdx_mem_req_dropped", mem_req_valid, 1'b0);
        repeat (4) step();
        chk("rdx_waiting", done_valid, 1'b0);
        mem_resp_valid = 1'b1;
        step();
        mem_resp_valid = 1'b0;
        chk_done("rdx", 2'd1, 1'b0, 1'b0, 1'b0);
        step();

        // Core 3 BusWB writes back to memory.
        issue("wb", 2'd3, 2'b11, 64'h80);
        snp_ack = 4'b0111;
        step();
        snp_ack = 4'd0;
        chk("wb_mem_req_valid", mem_req_valid, 1'b1);
        chk("wb_mem_write", mem_req_write, 1'b1);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        step();
        mem_resp_valid = 1'b0;
        chk_done("wb", 2'd3, 1'b0, 1'b0, 1'b0);
        step();

        // Core 2 BusRd, clean shared copy in core 0, data from memory installs S.
        issue("rdsh", 2'd2, 2'b00, 64'h2C0);
        snp_ack = 4'b1011; snp_shared = 4'b0001;
        step();
        snp_ack = 4'd0; snp_shared = 4'd0;
        chk("rdsh_mem_write", mem_req_write, 1'b0);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        step();
        mem_resp_valid = 1'b0;
        chk_done("rdsh", 2'd2, 1'b1, 1'b0, 1'b0);
        step();

        // Core 2 BusRd, core 1 never acks: error exactly 64 cycles after COLLECT entry.
        issue("tmo", 2'd2, 2'b00, 64'h300);
        snp_ack = 4'b1001;
        step();
        snp_ack = 4'd0;
        repeat (62) step();
        chk("tmo_not_yet_T65", done_valid, 1'b0);
        step();
        chk_done("tmo", 2'd2, 1'b0, 1'b0, 1'b1);
        step();

        // Two owners: error, no memory request.
        issue("own2", 2'd1, 2'b00, 64'h340);
        snp_ack = 4'b1101; snp_owner = 4'b0101;
        step();
        snp_ack = 4'd0; snp_owner = 4'd0;
        chk("own2_no_mem_req", mem_req_valid, 1'b0);
        chk_done("own2", 2'd1, 1'b1, 1'b0, 1'b1);
        step();

        // Reset while in MEM_WAIT aborts without a done pulse.
        issue("rst", 2'd0, 2'b00, 64'h200);
        snp_ack = 4'b1110;
        step();
        snp_ack = 4'd0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk("rst_in_mem_wait_busy", busy, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_ready", req_ready, 1'b1);
        chk("rst_async_busy", busy, 1'b0);
        chk("rst_async_snp_addr", snp_addr, 64'd0);
        chk("rst_async_mem_addr", mem_req_addr, 64'd0);
        chk("rst_async_done_valid", done_valid, 1'b0);
        step();
        rst_n = 1'b1;
        mem_resp_valid = 1'b1;
        step();
        mem_resp_valid = 1'b0;
        chk("rst_late_resp_no_done", done_valid, 1'b0);
        chk("rst_late_resp_idle", busy, 1'b0);
        issue("post", 2'd2, 2'b10, 64'h1000);
        snp_ack = 4'b1011;
        step();
        snp_ack = 4'd0;
        chk_done("post", 2'd2, 1'b0, 1'b0, 1'b0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
